wb_register_file: RTL and testbench

- Architectural register file at the consuming end of the MEM/WB pipeline register.
- Holds 32 GPRs plus HI and LO. Commits writeback traffic (rf/hi/lo enables, destination rd, writeback data) on the clock edge.
- Serves two combinational GPR read ports and one HI/LO read port to the ID stage, with same-cycle write-to-read bypass.
- Keeps a retired-write counter for debug/verification.

---
 rtl/wb_register_file_pkg.sv | 13 +
 rtl/wb_register_file_if.sv | 34 +++
 rtl/wb_register_file_read_port.sv | 25 ++
 rtl/wb_register_file.sv | 86 ++++++++
 tb/tb_wb_register_file.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/wb_register_file_pkg.sv
// Shared pipeline constants so the MEM/WB register and the writeback
// register file agree on widths, special register indices and enable bits.
package wb_register_file_pkg;
   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 5;
   localparam int CNT_W     = 32;
   localparam int REG_ZERO  = 0;
   localparam int REG_RA    = 31;
   // Bit positions of the writeback enables inside the MEM/WB control bus.
   localparam int RF_EN_BIT = 9;
   localparam int HI_EN_BIT = 2;
   localparam int LO_EN_BIT = 1;
endpackage

// File: rtl/wb_register_file_if.sv
// Writeback/read bundle between the MEM/WB stage, the ID stage and the register file.
interface wb_register_file_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
);
   logic              rf_enable_wb;
   logic              hi_enable_wb;
   logic              lo_enable_wb;
   logic [ADDR_W-1:0] wb_rd;
   logic [DATA_W-1:0] wb_data;
   logic [DATA_W-1:0] wb_hilo_data;
   logic [ADDR_W-1:0] rs_addr;
   logic [ADDR_W-1:0] rt_addr;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;
   logic [DATA_W-1:0] hi_data;
   logic [DATA_W-1:0] lo_data;
   logic [CNT_W-1:0]  retired_writes;

   // Handshake: none. Writes are committed on every rising edge where an
   // enable is high; reads are combinational and valid in the same cycle.
   modport master (
      output rf_enable_wb, hi_enable_wb, lo_enable_wb, wb_rd, wb_data,
             wb_hilo_data, rs_addr, rt_addr,
      input  rs_data, rt_data, hi_data, lo_data, retired_writes
   );

   modport slave (
      input  rf_enable_wb, hi_enable_wb, lo_enable_wb, wb_rd, wb_data,
             wb_hilo_data, rs_addr, rt_addr,
      output rs_data, rt_data, hi_data, lo_data, retired_writes
   );
endinterface

// File: rtl/wb_register_file_read_port.sv
// One combinational GPR read port: r0 forced to zero, then same-cycle
// writeback bypass, then the stored register value.
module wb_register_file_read_port
   import wb_register_file_pkg::REG_ZERO;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic [ADDR_W-1:0]                 addr_i,
   input  logic [NUM_REGS-1:0][DATA_W-1:0]   regs_i,
   input  logic                              wr_en_i,
   input  logic [ADDR_W-1:0]                 wr_addr_i,
   input  logic [DATA_W-1:0]                 wr_data_i,
   output logic [DATA_W-1:0]                 data_o
);
   always_comb begin
      data_o = regs_i[addr_i];
      if (addr_i == ADDR_W'(REG_ZERO)) begin
         data_o = '0;
      end else if (wr_en_i && (wr_addr_i == addr_i)) begin
         data_o = wr_data_i;
      end
   end
endmodule

// File: rtl/wb_register_file.sv
// Architectural GPR/HI/LO register file at the MEM/WB boundary with
// bypassed combinational reads and a retired-write counter.
module wb_register_file
   import wb_register_file_pkg::REG_ZERO;
#(
   parameter int DATA_W = wb_register_file_pkg::DATA_W,
   parameter int ADDR_W = wb_register_file_pkg::ADDR_W,
   parameter int CNT_W  = wb_register_file_pkg::CNT_W
) (
   input logic             clk,
   input logic             reset,
   wb_register_file_if.slave bus
);
   localparam int NUM_REGS = 1 << ADDR_W;

   logic [NUM_REGS-1:0][DATA_W-1:0] gpr_q;
   logic [DATA_W-1:0]               hi_q, hi_d;
   logic [DATA_W-1:0]               lo_q, lo_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic                            gpr_we;

   assign gpr_we = bus.rf_enable_wb && (bus.wb_rd != ADDR_W'(REG_ZERO));

   // hi_d/lo_d double as the bypassed read values: they already reflect the
   // pending write, including the mult/div pair routing of LO.
   always_comb begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      cnt_d = cnt_q;
      if (bus.hi_enable_wb) begin
         hi_d = bus.wb_data;
      end
      if (bus.lo_enable_wb) begin
         lo_d = bus.hi_enable_wb ? bus.wb_hilo_data : bus.wb_data;
      end
      if (gpr_we || bus.hi_enable_wb || bus.lo_enable_wb) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gpr_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (gpr_we) begin
            gpr_q[bus.wb_rd] <= bus.wb_data;
         end
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_d;
      end
   end

   wb_register_file_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_rs_port (
      .addr_i    (bus.rs_addr),
      .regs_i    (gpr_q),
      .wr_en_i   (bus.rf_enable_wb),
      .wr_addr_i (bus.wb_rd),
      .wr_data_i (bus.wb_data),
      .data_o    (bus.rs_data)
   );

   wb_register_file_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_rt_port (
      .addr_i    (bus.rt_addr),
      .regs_i    (gpr_q),
      .wr_en_i   (bus.rf_enable_wb),
      .wr_addr_i (bus.wb_rd),
      .wr_data_i (bus.wb_data),
      .data_o    (bus.rt_data)
   );

   assign bus.hi_data        = hi_d;
   assign bus.lo_data        = lo_d;
   assign bus.retired_writes = cnt_q;
endmodule

// File: tb/tb_wb_register_file.sv
module tb_wb_register_file;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic reset;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got [5];
  string         port_names [5] = '{"rs_data", "rt_data", "hi_data", "lo_data", "retired_writes"};

  logic [DW-1:0] model_gpr [32];
  logic [DW-1:0] model_hi;
  logic [DW-1:0] model_lo;
  logic [CW-1:0] model_cnt;

  wb_register_file_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

  wb_register_file #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic rf, input logic hi, input logic lo,
                       input logic [AW-1:0] rd, input logic [DW-1:0] d,
                       input logic [DW-1:0] hd, input logic [AW-1:0] rs,
                       input logic [AW-1:0] rt);
    bus.rf_enable_wb = rf;
    bus.hi_enable_wb = hi;
    bus.lo_enable_wb = lo;
    bus.wb_rd        = rd;
    bus.wb_data      = d;
    bus.wb_hilo_data = hd;
    bus.rs_addr      = rs;
    bus.rt_addr      = rt;
  endtask

  task automatic idle(input logic [AW-1:0] rs, input logic [AW-1:0] rt);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, rs, rt);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_gpr[i] = '0;
    model_hi  = '0;
    model_lo  = '0;
    model_cnt = '0;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (reset) begin
      if (bus.rf_enable_wb && bus.wb_rd != 0) model_gpr[bus.wb_rd] = bus.wb_data;
      if (bus.hi_enable_wb) model_hi = bus.wb_data;
      if (bus.lo_enable_wb) model_lo = bus.hi_enable_wb ? bus.wb_hilo_data : bus.wb_data;
      if ((bus.rf_enable_wb && bus.wb_rd != 0) || bus.hi_enable_wb || bus.lo_enable_wb)
        model_cnt = model_cnt + 1;
    end
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (bus.rf_enable_wb && bus.wb_rd == a) return bus.wb_data;
    return model_gpr[a];
  endfunction

  function automatic logic [DW-1:0] exp_hi();
    if (bus.hi_enable_wb) return bus.wb_data;
    return model_hi;
  endfunction

  function automatic logic [DW-1:0] exp_lo();
    if (bus.lo_enable_wb) return bus.hi_enable_wb ? bus.wb_hilo_data : bus.wb_data;
    return model_lo;
  endfunction

  task automatic push5(input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                       input logic [DW-1:0] e2, input logic [DW-1:0] e3,
                       input logic [DW-1:0] e4);
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    exp_q.push_back(e3);
    exp_q.push_back(e4);
  endtask

  task automatic sample_all();
    got[0] = bus.rs_data;
    got[1] = bus.rt_data;
    got[2] = bus.hi_data;
    got[3] = bus.lo_data;
    got[4] = bus.retired_writes;
  endtask

  task automatic compare_all(input string tag);
    logic [DW-1:0] exp;
    sample_all();
    for (int i = 0; i < 5; i++) begin
      exp = exp_q.pop_front();
      tests_run++;
      if (got[i] !== exp) begin
        tests_failed++;
        $display("FAIL %s %s got %h want %h", tag, port_names[i], got[i], exp);
      end
    end
  endtask

  task automatic check_model(input string tag);
    #1;
    push5(exp_read(bus.rs_addr), exp_read(bus.rt_addr), exp_hi(), exp_lo(), DW'(model_cnt));
    compare_all(tag);
  endtask

  task automatic check_lit(input string tag, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                           input logic [DW-1:0] e2, input logic [DW-1:0] e3,
                           input logic [DW-1:0] e4);
    #1;
    push5(e0, e1, e2, e3, e4);
    compare_all(tag);
  endtask

  initial begin
    reset = 1'b0;
    model_clear();
    idle(5'd5, 5'd31);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_lit("reset", '0, '0, '0, '0, '0);

    drive(1'b1, 1'b0, 1'b0, 5'd7, 32'hDEADBEEF, '0, 5'd7, 5'd7);
    check_lit("gpr_bypass", 32'hDEADBEEF, 32'hDEADBEEF, '0, '0, 32'd0);
    clock_edge();
    idle(5'd7, 5'd0);
    check_lit("gpr_commit", 32'hDEADBEEF, '0, '0, '0, 32'd1);

    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h12345678, '0, 5'd0, 5'd0);
    check_lit("r0_bypass", '0, '0, '0, '0, 32'd1);
    clock_edge();
    idle(5'd0, 5'd7);
    check_lit("r0_commit", '0, 32'hDEADBEEF, '0, '0, 32'd1);

    drive(1'b0, 1'b1, 1'b1, 5'd0, 32'h00000001, 32'hFFFFFFFE, 5'd7, 5'd0);
    check_lit("hilo_bypass", 32'hDEADBEEF, '0, 32'h1, 32'hFFFFFFFE, 32'd1);
    clock_edge();
    idle(5'd7, 5'd0);
    check_lit("hilo_commit", 32'hDEADBEEF, '0, 32'h1, 32'hFFFFFFFE, 32'd2);

    drive(1'b1, 1'b0, 1'b1, 5'd31, 32'hA5A5A5A5, '0, 5'd31, 5'd31);
    check_model("rf_lo_bypass");
    clock_edge();
    idle(5'd31, 5'd31);
    check_model("rf_lo_commit");
    drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h55, '0, 5'd31, 5'd31);
    clock_edge();
    idle(5'd31, 5'd31);
    check_lit("rf_lo_final", 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1, 32'h55, 32'd4);

    drive(1'b1, 1'b0, 1'b0, 5'd3, 32'hCAFEF00D, '0, 5'd4, 5'd5);
    #2;
    reset = 1'b0;
    model_clear();
    check_lit("async_reset", '0, '0, '0, '0, '0);
    clock_edge();
    idle(5'd3, 5'd3);
    reset = 1'b1;
    check_lit("reset_r3", '0, '0, '0, '0, '0);

    for (int n = 0; n < 40; n++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 31), $urandom(), $urandom(),
            $urandom_range(0, 31), $urandom_range(0, 31));
      check_model("rand_bypass");
      clock_edge();
    end
    idle(5'd1, 5'd2);
    check_model("rand_final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    if (tests_failed == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end
endmodule
